// File: rtl/bsg_nonsynth_non_blocking_dma_model_pipelined_pkg.sv
// Shared constants and helpers for the pipelined non-blocking DMA memory model.
// Holds the packet width rule, the wrap-safe due check and the delay generator step.
package bsg_nonsynth_non_blocking_dma_model_pipelined_pkg;

  localparam int unsigned NOW_W = 32;

  // Packet layout is {write_not_read, addr}.
  function automatic int unsigned dma_pkt_width(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  // Signed difference keeps the comparison correct across counter wrap-around.
  function automatic logic due_reached(input logic [NOW_W-1:0] now,
                                       input logic [NOW_W-1:0] due);
    logic [NOW_W-1:0] diff;
    diff = now - due;
    return ~diff[NOW_W-1];
  endfunction

  function automatic logic [NOW_W-1:0] xorshift(input logic [NOW_W-1:0] x);
    logic [NOW_W-1:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

endpackage

// File: rtl/bsg_nonsynth_non_blocking_dma_model_pipelined_rdq.sv
// In-order read queue of {block, due} entries with a valid/block shadow so the
// write path can check for a same-block hazard against every queued read.
module bsg_nonsynth_non_blocking_dma_model_pipelined_rdq
  import bsg_nonsynth_non_blocking_dma_model_pipelined_pkg::*;
#(
  parameter int unsigned BLK_W = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enq_i,
  input  logic [BLK_W-1:0] enq_blk_i,
  input  logic [NOW_W-1:0] enq_due_i,
  input  logic             deq_i,
  input  logic [BLK_W-1:0] query_blk_i,
  output logic             hit_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [BLK_W-1:0] head_blk_o,
  output logic [NOW_W-1:0] head_due_o,
  output logic             second_v_o,
  output logic [NOW_W-1:0] second_due_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] rptr_q, wptr_q, rptr_nx;
  logic [CNT_W-1:0] count_q;
  logic             valid_q [DEPTH];
  logic [BLK_W-1:0] blk_q   [DEPTH];
  logic [NOW_W-1:0] due_q   [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign rptr_nx      = ptr_inc(rptr_q);
  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;
  assign head_blk_o   = blk_q[rptr_q];
  assign head_due_o   = due_q[rptr_q];
  assign second_v_o   = (count_q > CNT_W'(1));
  assign second_due_o = due_q[rptr_nx];

  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (blk_q[i] == query_blk_i)) hit_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        blk_q[i]   <= '0;
        due_q[i]   <= '0;
      end
    end else begin
      if (enq_i) begin
        valid_q[wptr_q] <= 1'b1;
        blk_q[wptr_q]   <= enq_blk_i;
        due_q[wptr_q]   <= enq_due_i;
        wptr_q          <= ptr_inc(wptr_q);
      end
      if (deq_i) begin
        valid_q[rptr_q] <= 1'b0;
        rptr_q          <= rptr_nx;
      end
      if (enq_i && !deq_i)      count_q <= count_q + CNT_W'(1);
      else if (!enq_i && deq_i) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/bsg_nonsynth_non_blocking_dma_model_pipelined.sv
// Block-granular DMA memory model with several in-order outstanding reads, one
// streaming write channel and block-level read/write hazard interlocks.
module bsg_nonsynth_non_blocking_dma_model_pipelined
  import bsg_nonsynth_non_blocking_dma_model_pipelined_pkg::*;
#(
  parameter int unsigned addr_width_p          = 32,
  parameter int unsigned data_width_p          = 32,
  parameter int unsigned block_size_in_words_p = 4,
  parameter int unsigned els_p                 = 1024,
  parameter int unsigned max_reads_p           = 4,
  parameter int unsigned read_latency_p        = 8,
  parameter int unsigned random_delay_p        = 0,
  parameter int unsigned max_delay_p           = 16
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [dma_pkt_width(addr_width_p)-1:0]    dma_pkt_i,
  input  logic                                      dma_pkt_v_i,
  output logic                                      dma_pkt_yumi_o,
  output logic [data_width_p-1:0]                   dma_data_o,
  output logic                                      dma_data_v_o,
  input  logic                                      dma_data_ready_i,
  input  logic [data_width_p-1:0]                   dma_data_i,
  input  logic                                      dma_data_v_i,
  output logic                                      dma_data_yumi_o,
  output logic [$clog2(max_reads_p+1)-1:0]          reads_outstanding_o
);

  localparam int unsigned BYTE_LSB = $clog2(data_width_p / 8);
  localparam int unsigned CNT_W    = $clog2(block_size_in_words_p);
  localparam int unsigned BLK_LSB  = BYTE_LSB + CNT_W;
  localparam int unsigned BLK_W    = addr_width_p - BLK_LSB;
  localparam int unsigned IDX_W    = $clog2(els_p);
  localparam int unsigned MBLK_W   = IDX_W - CNT_W;

  typedef enum logic {R_IDLE, R_SEND} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_GAP, W_RECV} wr_state_e;

  rd_state_e         rd_state_q, rd_state_d;
  wr_state_e         wr_state_q, wr_state_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [BLK_W-1:0]  wr_blk_q, wr_blk_d;
  logic [NOW_W-1:0]  gap_q, gap_d, now_q, lfsr_q, rnd;
  logic [data_width_p-1:0] mem_q [els_p];

  logic              pkt_wnr, wr_active, rd_accept, wr_accept, deq, wr_beat;
  logic [BLK_W-1:0]  pkt_blk, head_blk;
  logic [NOW_W-1:0]  head_due, second_due;
  logic              q_hit, q_full, q_empty, second_v;
  logic              unused_bits;

  assign pkt_wnr   = dma_pkt_i[addr_width_p];
  assign pkt_blk   = dma_pkt_i[addr_width_p-1:BLK_LSB];
  assign wr_active = (wr_state_q != W_IDLE);

  // One packet is presented at a time, so at most one of these can fire.
  assign rd_accept = ~reset_i & dma_pkt_v_i & ~pkt_wnr & ~q_full
                   & ~(wr_active & (wr_blk_q == pkt_blk));
  assign wr_accept = ~reset_i & dma_pkt_v_i & pkt_wnr & ~wr_active & ~q_hit;
  assign dma_pkt_yumi_o = rd_accept | wr_accept;

  always_comb begin
    rnd = '0;
    if (random_delay_p != 0) rnd = lfsr_q % NOW_W'(max_delay_p + 1);
  end

  bsg_nonsynth_non_blocking_dma_model_pipelined_rdq #(
    .BLK_W (BLK_W),
    .DEPTH (max_reads_p),
    .CNT_W ($clog2(max_reads_p + 1))
  ) rdq (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .enq_i        (rd_accept),
    .enq_blk_i    (pkt_blk),
    .enq_due_i    (now_q + NOW_W'(read_latency_p) + rnd),
    .deq_i        (deq),
    .query_blk_i  (pkt_blk),
    .hit_o        (q_hit),
    .full_o       (q_full),
    .empty_o      (q_empty),
    .head_blk_o   (head_blk),
    .head_due_o   (head_due),
    .second_v_o   (second_v),
    .second_due_o (second_due),
    .count_o      (reads_outstanding_o)
  );

  assign dma_data_o = mem_q[{head_blk[MBLK_W-1:0], rd_cnt_q}];

  // Looking one cycle ahead lets the first beat appear exactly read_latency_p after accept.
  always_comb begin
    rd_state_d   = rd_state_q;
    rd_cnt_d     = rd_cnt_q;
    deq          = 1'b0;
    dma_data_v_o = 1'b0;
    case (rd_state_q)
      R_IDLE: if (!q_empty && due_reached(now_q + NOW_W'(1), head_due)) rd_state_d = R_SEND;
      R_SEND: begin
        dma_data_v_o = 1'b1;
        if (dma_data_ready_i) begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
          if (rd_cnt_q == '1) begin
            deq = 1'b1;
            if (!(second_v && due_reached(now_q + NOW_W'(1), second_due))) rd_state_d = R_IDLE;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign wr_beat = (wr_state_q == W_RECV) && dma_data_v_i;

  always_comb begin
    wr_state_d      = wr_state_q;
    wr_blk_d        = wr_blk_q;
    wr_cnt_d        = wr_cnt_q;
    gap_d           = gap_q;
    dma_data_yumi_o = 1'b0;
    case (wr_state_q)
      W_IDLE: if (wr_accept) begin
        wr_state_d = W_GAP;
        wr_blk_d   = pkt_blk;
        wr_cnt_d   = '0;
        gap_d      = rnd;
      end
      W_GAP: begin
        if (gap_q == '0) wr_state_d = W_RECV;
        else             gap_d = gap_q - NOW_W'(1);
      end
      W_RECV: begin
        dma_data_yumi_o = dma_data_v_i;
        if (dma_data_v_i) begin
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
          if (wr_cnt_q == '1) begin
            wr_state_d = W_IDLE;
          end else if (rnd != '0) begin
            wr_state_d = W_GAP;
            gap_d      = rnd - NOW_W'(1);
          end
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      now_q      <= '0;
      lfsr_q     <= NOW_W'(1);
      rd_state_q <= R_IDLE;
      rd_cnt_q   <= '0;
      wr_state_q <= W_IDLE;
      wr_blk_q   <= '0;
      wr_cnt_q   <= '0;
      gap_q      <= '0;
    end else begin
      now_q      <= now_q + NOW_W'(1);
      lfsr_q     <= xorshift(lfsr_q);
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_state_q <= wr_state_d;
      wr_blk_q   <= wr_blk_d;
      wr_cnt_q   <= wr_cnt_d;
      gap_q      <= gap_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < els_p; i++) mem_q[i] <= '0;
    end else if (wr_beat) begin
      mem_q[{wr_blk_q[MBLK_W-1:0], wr_cnt_q}] <= dma_data_i;
    end
  end

  assign unused_bits = ^{dma_pkt_i[BLK_LSB-1:0], head_blk[BLK_W-1:MBLK_W],
                         wr_blk_q[BLK_W-1:MBLK_W]};

endmodule

// File: tb/tb_bsg_nonsynth_non_blocking_dma_model_pipelined.sv
// Scoreboard bench for the pipelined DMA model in fixed-latency mode.
module tb_bsg_nonsynth_non_blocking_dma_model_pipelined;

  localparam int AW = 16, DW = 32, BW = 4, ELS = 1024, MR = 4, LAT = 8;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [AW:0]   dma_pkt_i;
  logic          dma_pkt_v_i, dma_pkt_yumi_o;
  logic [DW-1:0] dma_data_o, dma_data_i;
  logic          dma_data_v_o, dma_data_ready_i, dma_data_v_i, dma_data_yumi_o;
  logic [2:0]    reads_outstanding_o;

  always #5 clk = ~clk;

  bsg_nonsynth_non_blocking_dma_model_pipelined #(
    .addr_width_p(AW), .data_width_p(DW), .block_size_in_words_p(BW), .els_p(ELS),
    .max_reads_p(MR), .read_latency_p(LAT), .random_delay_p(0), .max_delay_p(16)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i),
    .dma_pkt_yumi_o(dma_pkt_yumi_o), .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o),
    .dma_data_ready_i(dma_data_ready_i), .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i),
    .dma_data_yumi_o(dma_data_yumi_o), .reads_outstanding_o(reads_outstanding_o)
  );

  int            checks = 0, errors = 0, cyc = 0;
  logic [DW-1:0] model_mem [ELS];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] wq [$];
  int            beat_cyc [$];
  int            ready_mode = 0, last_wbeat_cyc = -100, max_out = 0;
  bit            wgap_en = 1'b0, held = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // write data source
  initial begin
    dma_data_v_i = 1'b0;
    dma_data_i   = '0;
    forever begin
      @(posedge clk); #1;
      if (wq.size() > 0 && (!wgap_en || $urandom_range(1, 0) == 1)) begin
        dma_data_v_i = 1'b1;
        dma_data_i   = wq[0];
      end else begin
        dma_data_v_i = 1'b0;
        dma_data_i   = '0;
      end
      @(negedge clk);
      if (!reset_i && dma_data_v_i && dma_data_yumi_o && wq.size() > 0) begin
        void'(wq.pop_front());
        last_wbeat_cyc = cyc;
      end
    end
  end

  initial begin
    dma_data_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       dma_data_ready_i = 1'b1;
        1:       dma_data_ready_i = ~dma_data_ready_i;
        default: dma_data_ready_i = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // read beat monitor
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset_i) begin
        if (held) begin
          checks++;
          if (dma_data_v_o !== 1'b1) begin
            errors++;
            $display("FAIL valid_hold cyc %0d got %b want 1", cyc, dma_data_v_o);
          end
        end
        if (int'(reads_outstanding_o) > max_out) max_out = int'(reads_outstanding_o);
        if (dma_data_v_o && dma_data_ready_i) begin
          beat_cyc.push_back(cyc);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_beat cyc %0d got %h want no beat", cyc, dma_data_o);
          end else begin
            e = exp_q.pop_front();
            if (dma_data_o !== e) begin
              errors++;
              $display("FAIL rd_beat cyc %0d got %h want %h", cyc, dma_data_o, e);
            end
          end
        end
        held = dma_data_v_o && !dma_data_ready_i;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [4*DW-1:0] blk4(input logic [DW-1:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic int bc(input int i);
    return (beat_cyc.size() > i) ? beat_cyc[i] : -1000;
  endfunction

  // Entered and left at posedge+1 so packets can be issued back to back.
  task automatic send_pkt(input bit wnr, input logic [AW-1:0] addr, input logic [4*DW-1:0] wd,
                          output int acc_cyc, output int out_at);
    int  n, base;
    bit  done;
    base = int'(addr[11:4]) * BW;
    dma_pkt_i   = {wnr, addr};
    dma_pkt_v_i = 1'b1;
    acc_cyc = -1; out_at = -1; done = 1'b0; n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      if (dma_pkt_yumi_o) begin
        acc_cyc = cyc;
        out_at  = int'(reads_outstanding_o);
        for (int k = 0; k < BW; k++) begin
          if (wnr) begin
            model_mem[base + k] = wd[k*DW +: DW];
            wq.push_back(wd[k*DW +: DW]);
          end else begin
            exp_q.push_back(model_mem[base + k]);
          end
        end
        done = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    dma_pkt_v_i = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL pkt_accept addr %h got no yumi want yumi", addr);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || wq.size() != 0 || dma_data_v_o) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL drain_%s got pending %0d want 0", name, exp_q.size());
    end
  endtask

  task automatic wait_beats(input int want);
    int n = 0;
    while (beat_cyc.size() < want && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (beat_cyc.size() < want) begin
      errors++;
      $display("FAIL beat_count got %0d want %0d", beat_cyc.size(), want);
    end
  endtask

  task automatic test_reset();
    reset_i     = 1'b1;
    dma_pkt_i   = {1'b0, 16'h0000};
    dma_pkt_v_i = 1'b1;
    #8;
    checks += 5;
    if (dma_pkt_yumi_o !== 1'b0) begin errors++; $display("FAIL rst_pkt_yumi got %b want 0", dma_pkt_yumi_o); end
    if (dma_data_v_o !== 1'b0) begin errors++; $display("FAIL rst_data_v got %b want 0", dma_data_v_o); end
    if (dma_data_yumi_o !== 1'b0) begin errors++; $display("FAIL rst_data_yumi got %b want 0", dma_data_yumi_o); end
    if (reads_outstanding_o !== 3'd0) begin errors++; $display("FAIL rst_outstanding got %0d want 0", reads_outstanding_o); end
    if (dma_data_o !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 0", dma_data_o); end
    #4;
    dma_pkt_v_i = 1'b0;
    reset_i     = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_first_read();
    int acc, oa;
    beat_cyc.delete();
    send_pkt(1'b0, 16'h0000, '0, acc, oa);
    wait_beats(4);
    checks += 2;
    if (bc(0) - acc != LAT) begin errors++; $display("FAIL first_latency got %0d want %0d", bc(0) - acc, LAT); end
    if (bc(3) - bc(0) != 3) begin errors++; $display("FAIL first_burst got %0d want 3", bc(3) - bc(0)); end
    drain("first");
  endtask

  task automatic test_write_then_read();
    int aw, ar, oa;
    last_wbeat_cyc = -100;
    send_pkt(1'b1, 16'h0040, blk4(32'd1, 32'd2, 32'd3, 32'd4), aw, oa);
    send_pkt(1'b0, 16'h0040, '0, ar, oa);
    checks++;
    if (ar != last_wbeat_cyc + 1) begin
      errors++;
      $display("FAIL raw_accept got %0d want %0d", ar, last_wbeat_cyc + 1);
    end
    drain("wr_rd");
  endtask

  task automatic test_back_to_back();
    int acc [5];
    int oa  [5];
    beat_cyc.delete();
    max_out = 0;
    for (int k = 0; k < 5; k++) send_pkt(1'b0, 16'((8 + k) << 4), '0, acc[k], oa[k]);
    for (int k = 0; k < 4; k++) begin
      checks += 2;
      if (oa[k] != k) begin errors++; $display("FAIL b2b_out%0d got %0d want %0d", k, oa[k], k); end
      if (acc[k] != acc[0] + k) begin errors++; $display("FAIL b2b_acc%0d got %0d want %0d", k, acc[k], acc[0] + k); end
    end
    checks += 2;
    if (acc[4] != acc[0] + 12) begin errors++; $display("FAIL b2b_fifth_acc got %0d want %0d", acc[4], acc[0] + 12); end
    if (oa[4] != 3) begin errors++; $display("FAIL b2b_fifth_out got %0d want 3", oa[4]); end
    wait_beats(20);
    checks += 3;
    if (bc(0) != acc[0] + LAT) begin errors++; $display("FAIL b2b_first got %0d want %0d", bc(0), acc[0] + LAT); end
    if (bc(15) - bc(0) != 15) begin errors++; $display("FAIL b2b_stream got %0d want 15", bc(15) - bc(0)); end
    if (max_out != 4) begin errors++; $display("FAIL b2b_max_out got %0d want 4", max_out); end
    drain("b2b");
  endtask

  task automatic test_ready_toggle();
    int a, o;
    beat_cyc.delete();
    ready_mode = 1;
    send_pkt(1'b0, 16'h0040, '0, a, o);
    send_pkt(1'b0, 16'h0000, '0, a, o);
    send_pkt(1'b0, 16'h0040, '0, a, o);
    drain("toggle");
    ready_mode = 0;
    checks++;
    if (beat_cyc.size() != 12) begin errors++; $display("FAIL toggle_beats got %0d want 12", beat_cyc.size()); end
  endtask

  task automatic test_rw_hazard();
    int a, o, aw;
    send_pkt(1'b1, 16'h0080, blk4(32'd10, 32'd11, 32'd12, 32'd13), a, o);
    drain("hz_init");
    beat_cyc.delete();
    send_pkt(1'b0, 16'h0080, '0, a, o);
    send_pkt(1'b1, 16'h0080, blk4(32'd20, 32'd21, 32'd22, 32'd23), aw, o);
    checks++;
    if (aw != bc(3) + 1) begin errors++; $display("FAIL war_accept got %0d want %0d", aw, bc(3) + 1); end
    send_pkt(1'b0, 16'h0080, '0, a, o);
    drain("hazard");
  endtask

  task automatic test_random_mixed();
    int a, o;
    logic [AW-1:0] addr;
    ready_mode = 2;
    wgap_en    = 1'b1;
    for (int i = 0; i < 400; i++) begin
      addr = 16'((16 + $urandom_range(7, 0)) << 4);
      send_pkt($urandom_range(2, 0) == 0, addr,
               blk4($urandom, $urandom, $urandom, $urandom), a, o);
    end
    drain("random");
    ready_mode = 0;
    wgap_en    = 1'b0;
  endtask

  task automatic test_reset_mid_send();
    int a, o, n;
    send_pkt(1'b0, 16'h0040, '0, a, o);
    n = 0;
    while (!dma_data_v_o && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (!dma_data_v_o) begin errors++; $display("FAIL mid_send_start got 0 want 1"); end
    @(negedge clk); #2;
    reset_i = 1'b1;
    #1;
    checks += 4;
    if (dma_data_v_o !== 1'b0) begin errors++; $display("FAIL midrst_data_v got %b want 0", dma_data_v_o); end
    if (dma_data_yumi_o !== 1'b0) begin errors++; $display("FAIL midrst_data_yumi got %b want 0", dma_data_yumi_o); end
    if (reads_outstanding_o !== 3'd0) begin errors++; $display("FAIL midrst_outstanding got %0d want 0", reads_outstanding_o); end
    if (dma_data_o !== 32'h0) begin errors++; $display("FAIL midrst_data got %h want 0", dma_data_o); end
    exp_q.delete();
    wq.delete();
    held = 1'b0;
    for (int i = 0; i < ELS; i++) model_mem[i] = '0;
    @(posedge clk); #2;
    reset_i = 1'b0;
    @(posedge clk); #1;
    send_pkt(1'b0, 16'h0040, '0, a, o);
    drain("post_reset");
  endtask

  initial begin
    for (int i = 0; i < ELS; i++) model_mem[i] = '0;
    dma_pkt_i   = '0;
    dma_pkt_v_i = 1'b0;
    test_reset();
    test_first_read();
    test_write_then_read();
    test_back_to_back();
    test_ready_toggle();
    test_rw_hazard();
    test_random_mixed();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
